// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: drives a 2N-bit multiplier scan chain and runs one test vector per start.
// Per vector: shift in {op_a, op_b} LSB first, one capture cycle, shift out the 2N-bit
// product LSB first, then present result/pass with a one-cycle done pulse.
// Optional feature macro: SCAN_CTRL_CHECK_EN (expected-product compare, pass, err_cnt).
module scan_test_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     op_a,
  input  logic [N-1:0]     op_b,
  input  logic [2*N-1:0]   exp_prod,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   result,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             scan_en,
  output logic             scan_in,
  input  logic             scan_out
);

  localparam int unsigned CHAIN_W = 2 * N;
  localparam int unsigned BIT_W   = 5;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [CHAIN_W-1:0] vec_sh, vec_sh_nxt;
  logic [CHAIN_W-1:0] res_sh, res_sh_nxt;
  logic [CHAIN_W-1:0] result_nxt;
  logic [CNT_W-1:0]   vec_cnt_nxt;
  logic               scan_en_nxt;
  logic               scan_in_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic [CHAIN_W-1:0] prod_c;

  // Full product as it stands at the closing edge of the last SHIFT_OUT cycle.
  assign prod_c = {scan_out, res_sh[CHAIN_W-1:1]};

`ifdef SCAN_CTRL_CHECK_EN
  logic [CHAIN_W-1:0] exp_q, exp_nxt;
  logic               pass_q, pass_nxt;
  logic [CNT_W-1:0]   err_q, err_nxt;

  assign pass    = pass_q;
  assign err_cnt = err_q;
`else
  logic unused_exp_prod;

  // Compare path is absent: expected product is never consumed.
  assign unused_exp_prod = ^exp_prod;
  assign pass            = 1'b0;
  assign err_cnt         = '0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    vec_sh_nxt  = vec_sh;
    res_sh_nxt  = res_sh;
    result_nxt  = result;
    vec_cnt_nxt = vec_cnt;
    scan_en_nxt = 1'b0;
    scan_in_nxt = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
`ifdef SCAN_CTRL_CHECK_EN
    exp_nxt     = exp_q;
    pass_nxt    = pass_q;
    err_nxt     = err_q;
`endif

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt   = S_SHIFT_IN;
          bit_cnt_nxt = '0;
          // Bit 0 goes out with the first SHIFT_IN cycle; the rest queue behind it.
          vec_sh_nxt  = CHAIN_W'({op_a, op_b} >> 1);
          scan_in_nxt = op_b[0];
          scan_en_nxt = 1'b1;
          busy_nxt    = 1'b1;
`ifdef SCAN_CTRL_CHECK_EN
          exp_nxt     = exp_prod;
`endif
        end else begin
          state_nxt = S_IDLE;
        end
      end

      S_SHIFT_IN: begin
        busy_nxt = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_nxt = S_CAPTURE;
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          scan_en_nxt = 1'b1;
          scan_in_nxt = vec_sh[0];
          vec_sh_nxt  = vec_sh >> 1;
        end
      end

      S_CAPTURE: begin
        state_nxt   = S_SHIFT_OUT;
        bit_cnt_nxt = '0;
        scan_en_nxt = 1'b1;
        busy_nxt    = 1'b1;
      end

      S_SHIFT_OUT: begin
        res_sh_nxt = prod_c;
        if (bit_cnt == LAST_BIT) begin
          state_nxt   = S_DONE;
          done_nxt    = 1'b1;
          result_nxt  = prod_c;
          vec_cnt_nxt = (vec_cnt == '1) ? vec_cnt : vec_cnt + CNT_W'(1);
`ifdef SCAN_CTRL_CHECK_EN
          pass_nxt    = (prod_c == exp_q);
          if ((prod_c != exp_q) && (err_q != '1)) begin
            err_nxt = err_q + CNT_W'(1);
          end
`endif
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          scan_en_nxt = 1'b1;
          busy_nxt    = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      vec_sh  <= '0;
      res_sh  <= '0;
      result  <= '0;
      vec_cnt <= '0;
      scan_en <= 1'b0;
      scan_in <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SCAN_CTRL_CHECK_EN
      exp_q   <= '0;
      pass_q  <= 1'b0;
      err_q   <= '0;
`endif
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      vec_sh  <= vec_sh_nxt;
      res_sh  <= res_sh_nxt;
      result  <= result_nxt;
      vec_cnt <= vec_cnt_nxt;
      scan_en <= scan_en_nxt;
      scan_in <= scan_in_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
`ifdef SCAN_CTRL_CHECK_EN
      exp_q   <= exp_nxt;
      pass_q  <= pass_nxt;
      err_q   <= err_nxt;
`endif
    end
  end

endmodule
